lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store access stage sitting directly upstream of the 2-read/1-write data memory.
- Accepts one load or store per cycle from the execute stage and drives the byte-addressed memory write port (byte mask plus replicated data) and one read port.
- Aligns and sign/zero-extends load data and returns a registered response to writeback through a valid/ready handshake.

Parameters:
- DEPTH, 32, memory depth in 32-bit words.
- MA_W, $clog2(DEPTH)+2, byte-address width presented to the memory (localparam, not overridable).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  stage can accept.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V width code: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  5  destination register tag.
- mem_addr  out  MA_W  byte address to memory read and write ports, = req_addr[MA_W-1:0].
- mem_we  out  1  memory write enable.
- mem_wmask  out  4  per-byte write enable.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  combinational read word from memory.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  extended load data; 0 for stores and errors.
- rsp_rd  out  5  tag; 0 for stores.
- rsp_err  out  1  access fault.

Behaviour:
- Reset, asynchronous and active-high: rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0. While rst=1, req_ready=0 and mem_we=0.
- Reset asserted mid-response drops the held response; no memory write occurs in that cycle.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (single-entry response register, full throughput).
  - accept = req_valid && req_ready.
  - On accept, the response register loads at the next edge. rsp_valid rises one cycle after accept (latency 1).
  - Response held stable while rsp_valid && !rsp_ready.
  - rsp_valid clears on a rsp_ready handshake with no simultaneous accept.
  - Accept and response handshake in the same cycle: the register is overwritten with the new response and rsp_valid stays 1.
- Every accepted request, load or store, produces exactly one response.
- Stores:
  - mem_we = accept && req_we && !fault, combinational. The memory commits at the same edge.
  - SB: wmask = 4'b0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011 << {addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111, wdata = wdata.
  - Response: data=0, rd=0, err=fault.
- Loads:
  - mem_rdata is sampled at the accept edge.
  - Byte lane = rdata >> (addr[1:0]*8); halfword lane = rdata >> (addr[1]*16).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_wmask=0 and mem_wdata=0 whenever mem_we=0.
- Address bits above MA_W are ignored, so addresses wrap modulo DEPTH*4.
- Fault conditions:
  - Illegal funct3 (loads 3/6/7; stores 3..7) always faults.
  - Faulting request: no write, rsp_err=1, rsp_data=0.
- Simultaneous load and store cannot occur (single request port). Read-after-write to the same word in back-to-back cycles returns the new data, because the memory is already updated at the read cycle.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, fault (err=1, no write).
- Undefined: misalignment never faults. Halfword ignores addr[0]; word ignores addr[1:0]. Only illegal funct3 sets rsp_err.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), BYTE_W=8, function lane_mask(funct3, addr[1:0]).
- Sub-module lsu_load_align (combinational): rdata, funct3, addr[1:0] -> 32-bit extended data.
- Top holds the handshake, fault decode, store formatting and the response register.

Test Plan:
- Reset then SW addr=0x8 data=0xDEADBEEF -> mem_we=1, wmask=1111, mem_addr=0x8; next cycle rsp_valid=1, rsp_err=0, rsp_rd=0.
- SB addr=0x9 data=0x000000A5 -> wmask=0010, wdata=0xA5A5A5A5; following LB addr=0x9 rd=3 -> rsp_data=0xFFFFFFA5, rsp_rd=3; LBU -> 0x000000A5.
- Word 0x80017FFF at 0x10: LH addr=0x12 -> 0xFFFF8001; LHU addr=0x10 -> 0x00007FFF.
- rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 after first accept, rsp_data stable, no mem_we; rsp_ready=1 -> back-to-back accept, rsp_valid stays 1.
- With LSU_MISALIGN_TRAP_EN: SW addr=0x6 -> mem_we=0, rsp_err=1, memory unchanged. Without it: same request writes word 0x4 with wmask=1111, rsp_err=0.
- Load funct3=3 -> rsp_err=1, rsp_data=0. Assert rst while rsp_valid=1 -> rsp_valid=0 immediately (asynchronous reset).

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store memory stage:
//               RISC-V funct3 width codes, byte width, the response record
//               and the store byte-lane mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int BYTE_W = 8;

    // Contents of the single-entry response register.
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } lsu_rsp_t;

    // Byte-lane enables for a store of the given width. Halfwords use only
    // addr[1] and words ignore the offset, so a misaligned access (when not
    // trapped) lands on the naturally aligned container.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (funct3)
            F3_B:    mask = 4'b0001 << addr_lo;
            F3_H:    mask = 4'b0011 << {addr_lo[1], 1'b0};
            F3_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_if
// Description : Bundle of the request handshake (execute -> stage), the
//               response handshake (stage -> writeback) and the memory port
//               (stage <-> data memory).
//               slave  : view of the lsu_mem_stage itself
//               master : view of the surrounding pipeline / memory
// Ports       : DEPTH parameter sets the memory-address width MA_W.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if #(
    parameter int DEPTH = 32
);
    localparam int MA_W = $clog2(DEPTH) + 2;

    // request
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [4:0]      req_rd;
    // memory port
    logic [MA_W-1:0] mem_addr;
    logic            mem_we;
    logic [3:0]      mem_wmask;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;
    // response
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [4:0]      rsp_rd;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_addr, mem_we, mem_wmask, mem_wdata,
        input  mem_rdata,
        output rsp_valid, rsp_data, rsp_rd, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_addr, mem_we, mem_wmask, mem_wdata,
        output mem_rdata,
        input  rsp_valid, rsp_data, rsp_rd, rsp_err,
        output rsp_ready
    );

endinterface : lsu_mem_stage_if
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load data alignment. Selects the addressed
//               byte/halfword lane from the memory word and sign- or
//               zero-extends it according to funct3.
// Ports       : rdata   - raw 32-bit memory word
//               funct3  - load width code
//               addr_lo - byte offset within the word
//               data    - extended result (0 for non-load codes)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_sh = rdata >> {addr_lo, 3'b000};
    assign w_half_sh = rdata >> {addr_lo[1], 4'b0000};
    assign w_byte    = w_byte_sh[BYTE_W-1:0];
    assign w_half    = w_half_sh[2*BYTE_W-1:0];

    always_comb begin
        data = 32'd0;
        case (funct3)
            F3_B:    data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   data = {24'd0, w_byte};
            F3_H:    data = {{16{w_half[15]}}, w_half};
            F3_HU:   data = {16'd0, w_half};
            F3_W:    data = rdata;
            default: data = 32'd0;
        endcase
    end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : Load/store access stage in front of a byte-addressed data
//               memory. Accepts one request per cycle, drives the memory
//               write port (byte mask + lane-replicated data) and read
//               address, aligns/extends load data and returns a registered
//               response over a valid/ready handshake.
// Ports       : clk, rst (async, active-high)
//               bus   - lsu_mem_stage_if.slave (request, memory, response)
// Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword and
//               word accesses fault instead of being silently aligned down.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DEPTH = 32
)(
    input  logic             clk,
    input  logic             rst,
    lsu_mem_stage_if.slave   bus
);

    localparam int MA_W = $clog2(DEPTH) + 2;

    logic       w_req_ready;
    logic       w_accept;
    logic       w_illegal;
    logic       w_misalign;
    logic       w_fault;
    logic       w_store_en;
    logic [1:0] w_addr_lo;
    logic [31:0] w_load_data;
    lsu_rsp_t   w_rsp_next;

    logic       r_rsp_valid;
    lsu_rsp_t   r_rsp;

    // Address bits above the memory range are dropped, so addresses wrap.
    logic w_unused_addr;
    assign w_unused_addr = ^bus.req_addr[31:MA_W];

    assign w_addr_lo = bus.req_addr[1:0];

    // Single-entry response register: accept whenever it is empty or being
    // drained this cycle. Gated by rst because the asynchronous reset clears
    // rsp_valid immediately and would otherwise open the port during reset.
    assign w_req_ready = !rst && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept    = bus.req_valid && w_req_ready;

    // ------------------------------------------------------------------
    // Fault decode
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal = 1'b1;
        if (bus.req_we) begin
            w_illegal = !(bus.req_funct3 == F3_B || bus.req_funct3 == F3_H ||
                          bus.req_funct3 == F3_W);
        end else begin
            w_illegal = !(bus.req_funct3 == F3_B  || bus.req_funct3 == F3_H  ||
                          bus.req_funct3 == F3_W  || bus.req_funct3 == F3_BU ||
                          bus.req_funct3 == F3_HU);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && w_addr_lo[0]) ||
                        ((bus.req_funct3 == F3_W) && (w_addr_lo != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = w_illegal || w_misalign;

    // ------------------------------------------------------------------
    // Store formatting (memory commits on the accept edge)
    // ------------------------------------------------------------------
    assign w_store_en    = w_accept && bus.req_we && !w_fault;
    assign bus.mem_addr  = bus.req_addr[MA_W-1:0];
    assign bus.mem_we    = w_store_en;
    assign bus.mem_wmask = w_store_en ? lane_mask(bus.req_funct3, w_addr_lo) : 4'b0000;

    always_comb begin
        bus.mem_wdata = 32'd0;
        if (w_store_en) begin
            case (bus.req_funct3)
                F3_B:    bus.mem_wdata = {4{bus.req_wdata[7:0]}};
                F3_H:    bus.mem_wdata = {2{bus.req_wdata[15:0]}};
                default: bus.mem_wdata = bus.req_wdata;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and response formation
    // ------------------------------------------------------------------
    lsu_load_align u_load_align (
        .rdata   (bus.mem_rdata),
        .funct3  (bus.req_funct3),
        .addr_lo (w_addr_lo),
        .data    (w_load_data)
    );

    always_comb begin
        w_rsp_next.data = 32'd0;
        w_rsp_next.rd   = 5'd0;
        w_rsp_next.err  = w_fault;
        if (!bus.req_we) begin
            w_rsp_next.rd   = bus.req_rd;
            w_rsp_next.data = w_fault ? 32'd0 : w_load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp       <= w_rsp_next;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp.data;
    assign bus.rsp_rd    = r_rsp.rd;
    assign bus.rsp_err   = r_rsp.err;

endmodule : lsu_mem_stage
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_stage
// Description : Self-checking bench for lsu_mem_stage. Provides a word
//               memory behind the stage and predicts every output from a
//               byte-array reference model of load/store semantics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

    localparam int DEPTH = 32;
    localparam int MA_W  = $clog2(DEPTH) + 2;
    localparam int NBYTE = DEPTH * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_stage_if #(.DEPTH(DEPTH)) bus ();

    lsu_mem_stage #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory behind the stage: combinational read, byte-masked write.
    logic [31:0] tb_mem [DEPTH];
    assign bus.mem_rdata = tb_mem[bus.mem_addr[MA_W-1:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wmask[i])
                    tb_mem[bus.mem_addr[MA_W-1:2]][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [NBYTE];
    bit          m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    logic        m_err;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, check outputs, advance the model.
    task automatic do_cycle(input bit v, input bit we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rd, input bit rr);
        bit          exp_ready, acc, legal, misal, fault, exp_we, sgn;
        int          n, idx, start;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata, val;

        @(negedge clk);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        bus.rsp_ready  = rr;
        #1;

        exp_ready = !m_valid || rr;
        check_val("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check_val("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check_val("rsp_data", bus.rsp_data, m_data);
            check_val("rsp_rd",   32'(bus.rsp_rd), 32'(m_rd));
            check_val("rsp_err",  32'(bus.rsp_err), 32'(m_err));
        end

        acc   = v && exp_ready;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << f3[1:0];
        idx   = int'(a % NBYTE);
`ifdef LSU_MISALIGN_TRAP_EN
        misal = legal && ((idx % n) != 0);
`else
        misal = 1'b0;
`endif
        fault  = !legal || misal;
        start  = legal ? (idx - (idx % n)) : idx;
        exp_we = acc && we && !fault;

        check_val("mem_addr", 32'(bus.mem_addr), a % NBYTE);
        check_val("mem_we", 32'(bus.mem_we), 32'(exp_we));

        exp_mask  = 4'b0000;
        exp_wdata = 32'd0;
        if (exp_we) begin
            for (int k = 0; k < n; k++) exp_mask[(start % 4) + k] = 1'b1;
            for (int i = 0; i < 4; i++) exp_wdata[i*8 +: 8] = wd[(i % n)*8 +: 8];
            for (int k = 0; k < n; k++) ref_mem[start + k] = wd[k*8 +: 8];
        end
        check_val("mem_wmask", 32'(bus.mem_wmask), 32'(exp_mask));
        check_val("mem_wdata", bus.mem_wdata, exp_wdata);

        if (acc) begin
            m_valid = 1'b1;
            m_err   = fault;
            m_rd    = we ? 5'd0 : rd;
            m_data  = 32'd0;
            if (!we && !fault) begin
                val = 32'd0;
                for (int k = 0; k < n; k++) val = val | (32'(ref_mem[start + k]) << (8 * k));
                sgn = (f3[2] == 1'b0);
                if (sgn && n == 1 && val[7])  val = val | 32'hFFFF_FF00;
                if (sgn && n == 2 && val[15]) val = val | 32'hFFFF_0000;
                m_data = val;
            end
        end else if (rr) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'd0;
        for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'd0;
        m_valid = 1'b0; m_data = 32'd0; m_rd = 5'd0; m_err = 1'b0;

        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h1111_1111; bus.req_rd = 5'd1;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_rsp_data",  bus.rsp_data, 32'd0);
        check_val("rst_rsp_rd",    32'(bus.rsp_rd), 32'd0);
        check_val("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("rst_mem_we",    32'(bus.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;

        // Directed sequence
        do_cycle(1, 1, 3'd2, 32'h8,  32'hDEAD_BEEF, 5'd0, 1);
        do_cycle(1, 1, 3'd0, 32'h9,  32'h0000_00A5, 5'd0, 1);
        do_cycle(1, 0, 3'd0, 32'h9,  32'h0,         5'd3, 1);
        @(posedge clk); #1;
        check_val("tp_lb_data", bus.rsp_data, 32'hFFFF_FFA5);
        check_val("tp_lb_rd",   32'(bus.rsp_rd), 32'd3);
        do_cycle(1, 0, 3'd4, 32'h9,  32'h0,         5'd4, 1);
        do_cycle(1, 1, 3'd2, 32'h10, 32'h8001_7FFF, 5'd0, 1);
        do_cycle(1, 0, 3'd1, 32'h12, 32'h0,         5'd5, 1);
        @(posedge clk); #1;
        check_val("tp_lh_data", bus.rsp_data, 32'hFFFF_8001);
        do_cycle(1, 0, 3'd5, 32'h10, 32'h0,         5'd6, 1);
        do_cycle(1, 0, 3'd2, 32'h8,  32'h0,         5'd7, 1);
        do_cycle(1, 0, 3'd3, 32'h8,  32'h0,         5'd8, 1);
        do_cycle(1, 1, 3'd2, 32'h6,  32'h1234_5678, 5'd0, 1);
        do_cycle(1, 0, 3'd2, 32'h4,  32'h0,         5'd9, 1);
        do_cycle(1, 1, 3'd5, 32'h4,  32'hFFFF_FFFF, 5'd0, 1);
        // Backpressure: consumer stalls for three cycles
        do_cycle(1, 0, 3'd2, 32'h10, 32'h0, 5'd10, 0);
        do_cycle(1, 1, 3'd2, 32'h14, 32'hCAFE_0001, 5'd0, 0);
        do_cycle(1, 1, 3'd2, 32'h14, 32'hCAFE_0002, 5'd0, 0);
        do_cycle(1, 0, 3'd0, 32'h11, 32'h0, 5'd11, 1);
        do_cycle(1, 0, 3'd1, 32'h8A, 32'h0, 5'd12, 1);   // wraps to 0x0A
        do_cycle(0, 0, 3'd0, 32'h0,  32'h0, 5'd0,  1);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                               : (($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2))
                                                                              : 3'($urandom_range(4, 5)));
            a = ($urandom & ~32'h1F) | 32'($urandom_range(0, 31));
            do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, f3, a,
                     $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
        end

        // Reset while a response is held: must vanish at once, no write.
        do_cycle(1, 1, 3'd2, 32'h18, 32'hAAAA_5555, 5'd0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h1C; bus.req_wdata = 32'h5A5A_5A5A; bus.rsp_ready = 1'b0;
        #1;
        check_val("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        rst = 1'b1;
        #1;
        check_val("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_val("mid_rst_mem_we",    32'(bus.mem_we), 32'd0);
        m_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        do_cycle(1, 0, 3'd2, 32'h1C, 32'h0, 5'd13, 1);
        do_cycle(0, 0, 3'd0, 32'h0,  32'h0, 5'd0,  1);
        @(posedge clk); #1;

        for (int w = 0; w < DEPTH; w++)
            check_val("mem_contents", tb_mem[w],
                      {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lsu_mem_stage
`default_nettype wire
